// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 434;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned COUNT_W          = 16;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, byte strobe and framing-error pulse.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              frame_err_pulse
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(BYTE_W);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  logic [1:0]        sync;
  logic              rx_s;
  rx_state_t         state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nx;
  logic [BYTE_W-1:0] shreg, shreg_nx;
  logic              valid_nx, ferr_nx;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync            <= 2'b11;
      state           <= RX_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else if (enable) begin
      sync            <= {sync[0], rx};
      state           <= state_nx;
      cnt             <= cnt_nx;
      bit_idx         <= bit_idx_nx;
      shreg           <= shreg_nx;
      byte_valid      <= valid_nx;
      frame_err_pulse <= ferr_nx;
    end
  end

  // Start is re-checked at half a bit; every later sample lands mid-bit.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_nx = RX_START;
          cnt_nx   = '0;
        end
      end
      RX_START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_nx     = '0;
          bit_idx_nx = '0;
          state_nx   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nx     = '0;
          shreg_nx   = {rx_s, shreg[BYTE_W-1:1]};
          bit_idx_nx = bit_idx + BIT_W'(1);
          if (bit_idx == BIT_W'(BYTE_W - 1)) state_nx = RX_STOP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nx   = '0;
          state_nx = RX_IDLE;
          valid_nx = rx_s;
          ferr_nx  = !rx_s;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_loader.sv
// Loads a UART byte stream (16-bit word count, then the words, high byte first)
// into memory through the shared addr/data/we write port.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  logic [BYTE_W-1:0]  rx_byte;
  logic               byte_valid;
  logic               frame_err_pulse;

  ld_state_t          state, state_nx;
  logic [BYTE_W-1:0]  hi_byte, hi_nx;
  logic [COUNT_W-1:0] count, count_nx;
  logic [DATA_W-1:0]  data_nx;
  logic [ADDR_W-1:0]  addr_nx;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .rx             (rx),
    .rx_byte        (rx_byte),
    .byte_valid     (byte_valid),
    .frame_err_pulse(frame_err_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LEN_HI;
      hi_byte   <= '0;
      count     <= '0;
      addr      <= ADDR_W'(BASE_ADDR);
      data      <= '0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state   <= state_nx;
      hi_byte <= hi_nx;
      count   <= count_nx;
      addr    <= addr_nx;
      data    <= data_nx;
      we      <= enable && (state_nx == WRITE);
      busy    <= enable && (state_nx != DONE);
      done    <= (state_nx == DONE);
      if (enable && frame_err_pulse) frame_err <= 1'b1;
    end
  end

  // High bytes wait in hi_byte so data only changes when a full word is ready.
  always_comb begin
    state_nx = state;
    hi_nx    = hi_byte;
    count_nx = count;
    data_nx  = data;
    addr_nx  = addr;
    if (enable) begin
      case (state)
        LEN_HI: begin
          if (byte_valid) begin
            hi_nx    = rx_byte;
            state_nx = LEN_LO;
          end
        end
        LEN_LO: begin
          if (byte_valid) begin
            count_nx = {hi_byte, rx_byte};
            state_nx = ({hi_byte, rx_byte} == COUNT_W'(0)) ? DONE : DATA_HI;
          end
        end
        DATA_HI: begin
          if (byte_valid) begin
            hi_nx    = rx_byte;
            state_nx = DATA_LO;
          end
        end
        DATA_LO: begin
          if (byte_valid) begin
            data_nx  = DATA_W'({hi_byte, rx_byte});
            state_nx = WRITE;
          end
        end
        WRITE: begin
          addr_nx  = addr + ADDR_W'(1);
          count_nx = count - COUNT_W'(1);
          state_nx = (count == COUNT_W'(1)) ? DONE : DATA_HI;
        end
        DONE:    state_nx = DONE;
        default: state_nx = LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: vector table, corner sequences, random streams.
`timescale 1ns/1ps
module tb_uart_loader;

  localparam int unsigned C       = 8;
  localparam int unsigned AW      = 15;
  localparam int unsigned DW      = 16;
  localparam int unsigned BASE_HI = 32'h7FFF;

  logic          clk = 1'b0;
  logic          reset, enable, rx;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          we0, we1, busy0, busy1, done0, done1, ferr0, ferr1;

  uart_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx),
    .addr(addr0), .data(data0), .we(we0), .busy(busy0), .done(done0), .frame_err(ferr0)
  );

  uart_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE_HI)) dut_hi (
    .clk(clk), .reset(reset), .enable(enable), .rx(rx),
    .addr(addr1), .data(data1), .we(we1), .busy(busy1), .done(done1), .frame_err(ferr1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log captured away from the active edge
  logic [AW-1:0] wa0[$], wa1[$];
  logic [DW-1:0] wd0[$], wd1[$];
  int   wide_cnt = 0;
  int   last_we_cyc = -1;
  int   done_rise_cyc = -1;
  logic we0_prev = 1'b0;
  logic done0_prev = 1'b0;

  always @(negedge clk) begin
    if (we0) begin
      wa0.push_back(addr0);
      wd0.push_back(data0);
      last_we_cyc = cyc;
    end
    if (we1) begin
      wa1.push_back(addr1);
      wd1.push_back(data1);
    end
    if (we0 && we0_prev) wide_cnt++;
    if (done0 && !done0_prev) done_rise_cyc = cyc;
    we0_prev   = we0;
    done0_prev = done0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    wide_cnt = 0; last_we_cyc = -1; done_rise_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx = 1'b1; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
    rx = 1'b1;
  endtask

  // Reference model: good bytes -> expected writes and completion
  logic [7:0]    good[$];
  logic [AW-1:0] ea[$];
  logic [DW-1:0] ed[$];
  logic          e_done;

  function automatic void model(input int unsigned base);
    int n;
    ea.delete(); ed.delete(); e_done = 1'b0;
    if (good.size() < 2) return;
    n = 256 * int'(good[0]) + int'(good[1]);
    for (int i = 0; i < n; i++) begin
      if (good.size() < 2 * i + 4) return;
      ea.push_back(AW'(base + 32'(i)));
      ed.push_back({good[2*i+2], good[2*i+3]});
    end
    e_done = 1'b1;
  endfunction

  task automatic cmp_writes(input string tag, input logic hi);
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    model(hi ? BASE_HI : 0);
    if (hi) begin qa = wa1; qd = wd1; end
    else    begin qa = wa0; qd = wd0; end
    chk($sformatf("%s_nwr", tag), 32'(qa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < qa.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), 32'(qa[i]), 32'(ea[i]));
      chk($sformatf("%s_d%0d", tag, i), 32'(qd[i]), 32'(ed[i]));
    end
  endtask

  typedef struct {
    int                  nb;
    logic [0:7][7:0]     b;
    int                  nw;
    logic [0:3][AW-1:0]  a;
    logic [0:3][DW-1:0]  d;
    logic                dn;
  } vec_t;

  vec_t vecs [5];

  initial begin
    reset = 1'b1; enable = 1'b1; rx = 1'b1;

    vecs[0] = '{6, {8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h00,8'h00}, 2,
                {15'h0,15'h1,15'h0,15'h0}, {16'h1234,16'hABCD,16'h0,16'h0}, 1'b1};
    vecs[1] = '{3, {8'h00,8'h00,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00}, 0,
                {15'h0,15'h0,15'h0,15'h0}, {16'h0,16'h0,16'h0,16'h0}, 1'b1};
    vecs[2] = '{4, {8'h00,8'h01,8'hBE,8'hEF,8'h00,8'h00,8'h00,8'h00}, 1,
                {15'h0,15'h0,15'h0,15'h0}, {16'hBEEF,16'h0,16'h0,16'h0}, 1'b1};
    vecs[3] = '{6, {8'h00,8'h02,8'h00,8'h01,8'h00,8'h02,8'h00,8'h00}, 2,
                {15'h0,15'h1,15'h0,15'h0}, {16'h0001,16'h0002,16'h0,16'h0}, 1'b1};
    vecs[4] = '{5, {8'h00,8'h03,8'h11,8'h22,8'h33,8'h00,8'h00,8'h00}, 1,
                {15'h0,15'h0,15'h0,15'h0}, {16'h1122,16'h0,16'h0,16'h0}, 1'b0};

    // Reset values and busy after release
    repeat (3) @(negedge clk);
    chk("rst_addr",   32'(addr0), 32'h0);
    chk("rst_addrhi", 32'(addr1), BASE_HI);
    chk("rst_data",   32'(data0), 32'h0);
    chk("rst_we",     32'(we0),   32'h0);
    chk("rst_busy",   32'(busy0), 32'h0);
    chk("rst_done",   32'(done0), 32'h0);
    chk("rst_ferr",   32'(ferr0), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_busy", 32'(busy0), 32'h1);

    // Vector table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      good.delete();
      for (int k = 0; k < vecs[v].nb; k++) begin
        send_byte(vecs[v].b[k], 1'b1);
        good.push_back(vecs[v].b[k]);
      end
      repeat (4 * C) @(negedge clk);
      chk($sformatf("v%0d_nwr", v), 32'(wa0.size()), 32'(vecs[v].nw));
      for (int i = 0; i < vecs[v].nw && i < wa0.size(); i++) begin
        chk($sformatf("v%0d_a%0d", v, i), 32'(wa0[i]), 32'(vecs[v].a[i]));
        chk($sformatf("v%0d_d%0d", v, i), 32'(wd0[i]), 32'(vecs[v].d[i]));
      end
      chk($sformatf("v%0d_done", v),  32'(done0), 32'(vecs[v].dn));
      chk($sformatf("v%0d_busy", v),  32'(busy0), 32'(!vecs[v].dn));
      chk($sformatf("v%0d_ferr", v),  32'(ferr0), 32'h0);
      chk($sformatf("v%0d_wide", v),  32'(wide_cnt), 32'h0);
      if (vecs[v].dn && vecs[v].nw > 0)
        chk($sformatf("v%0d_donelag", v), 32'(done_rise_cyc - last_we_cyc), 32'h1);
      cmp_writes($sformatf("v%0d_hi", v), 1'b1);
    end

    // Address wrap at the top of memory
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    repeat (4 * C) @(negedge clk);
    chk("wrap_nwr", 32'(wa1.size()), 32'h2);
    if (wa1.size() == 2) begin
      chk("wrap_a0", 32'(wa1[0]), 32'h7FFF);
      chk("wrap_d0", 32'(wd1[0]), 32'h0001);
      chk("wrap_a1", 32'(wa1[1]), 32'h0000);
      chk("wrap_d1", 32'(wd1[1]), 32'h0002);
    end
    chk("wrap_done", 32'(done1), 32'h1);

    // False start, then a framing error, then a one-word image
    do_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("fs_ferr", 32'(ferr0), 32'h0);
    send_byte(8'hA5, 1'b0);
    repeat (2 * C) @(negedge clk);
    chk("fe_ferr", 32'(ferr0), 32'h1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    repeat (4 * C) @(negedge clk);
    chk("fe_nwr", 32'(wa0.size()), 32'h1);
    if (wa0.size() == 1) begin
      chk("fe_a0", 32'(wa0[0]), 32'h0);
      chk("fe_d0", 32'(wd0[0]), 32'hBEEF);
    end
    chk("fe_done",  32'(done0), 32'h1);
    chk("fe_ferr2", 32'(ferr0), 32'h1);

    // Reset in the middle of a byte
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C + C / 2) @(negedge clk);
    chk("mr_pre_addr", 32'(addr0), 32'h1);
    chk("mr_pre_data", 32'(data0), 32'h1122);
    reset = 1'b1;
    #1;
    chk("mr_addr",   32'(addr0), 32'h0);
    chk("mr_addrhi", 32'(addr1), BASE_HI);
    chk("mr_data",   32'(data0), 32'h0);
    chk("mr_busy",   32'(busy0), 32'h0);
    chk("mr_done",   32'(done0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    repeat (4 * C) @(negedge clk);
    chk("mr_nwr", 32'(wa0.size()), 32'h1);
    if (wa0.size() == 1) begin
      chk("mr_a0", 32'(wa0[0]), 32'h0);
      chk("mr_d0", 32'(wd0[0]), 32'h2233);
    end
    chk("mr_done2", 32'(done0), 32'h1);

    // Bytes sent while disabled are not seen
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    repeat (C) @(negedge clk);
    enable = 1'b0;
    send_byte(8'h12, 1'b1);
    repeat (C) @(negedge clk);
    enable = 1'b1;
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    repeat (4 * C) @(negedge clk);
    chk("en_nwr", 32'(wa0.size()), 32'h1);
    if (wa0.size() == 1) chk("en_d0", 32'(wd0[0]), 32'h1234);
    chk("en_done", 32'(done0), 32'h1);

    // Random images with occasional framing errors and trailing junk
    for (int it = 0; it < 6; it++) begin
      logic [7:0] s[$];
      logic       ef;
      int         n;
      do_reset();
      good.delete();
      ef = 1'b0;
      n = $urandom_range(1, 3);
      s.push_back(8'h00);
      s.push_back(8'(n));
      for (int i = 0; i < 2 * n + int'($urandom_range(0, 2)); i++) s.push_back(8'($urandom));
      foreach (s[k]) begin
        if ($urandom_range(0, 5) == 0) begin
          send_byte(8'($urandom), 1'b0);
          repeat (2 * C) @(negedge clk);
          ef = 1'b1;
        end
        repeat ($urandom_range(0, C)) @(negedge clk);
        send_byte(s[k], 1'b1);
        good.push_back(s[k]);
      end
      repeat (4 * C) @(negedge clk);
      cmp_writes($sformatf("r%0d", it), 1'b0);
      chk($sformatf("r%0d_done", it), 32'(done0), 32'(e_done));
      chk($sformatf("r%0d_busy", it), 32'(busy0), 32'(!e_done));
      chk($sformatf("r%0d_ferr", it), 32'(ferr0), 32'(ef));
      chk($sformatf("r%0d_wide", it), 32'(wide_cnt), 32'h0);
      cmp_writes($sformatf("r%0d_hi", it), 1'b1);
      chk($sformatf("r%0d_done_hi", it), 32'(done1), 32'(e_done));
      chk($sformatf("r%0d_busy_hi", it), 32'(busy1), 32'(!e_done));
      chk($sformatf("r%0d_ferr_hi", it), 32'(ferr1), 32'(ef));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
